uart_tx_scheduler: RTL and testbench

//  Shares the single UART transmitter among NCH byte-stream requesters (CPU mailbox, debug, DMA).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rr_arbiter.sv | 39 +++
 rtl/uart_tx_scheduler.sv | 140 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and default limits.
package uart_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam int DEF_TIMEOUT  = 4096;
    localparam int DEF_HOLD_MAX = 256;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after i_ptr, else lowest overall.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] i_req,
    input  logic [2:0]     i_ptr,
    output logic [2:0]     o_gnt_idx,
    output logic           o_gnt_valid
);

    logic       w_hi_vld;
    logic [2:0] w_hi_idx;
    logic       w_lo_vld;
    logic [2:0] w_lo_idx;

    // Descending scan so the last hit written is the lowest index in each half.
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_vld = 1'b0;
        w_lo_idx = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                w_lo_vld = 1'b1;
                w_lo_idx = 3'(j);
                if (3'(j) >= i_ptr) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = 3'(j);
                end
            end
        end
    end

    assign o_gnt_valid = w_lo_vld;
    assign o_gnt_idx   = w_hi_vld ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NCH requesters with per-packet round-robin ownership,
// plus hold and TxDone timeouts so neither a stalled owner nor a dead transmitter can lock it up.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic             pClk,
    input  logic             pReset,
    input  logic [NCH-1:0]   req_valid,
    input  logic [8*NCH-1:0] req_data,
    input  logic [NCH-1:0]   req_last,
    output logic [NCH-1:0]   req_ready,
    input  logic             TxDone,
    output logic             TxEn,
    output logic [7:0]       TxData,
    output logic [2:0]       grant_id,
    output logic             busy,
    output logic             err_to
);

    localparam int CW = $clog2(max2(TIMEOUT, HOLD_MAX));
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
    localparam logic [CW-1:0] CNT_SAT   = '1;

    logic [1:0]    r_state;
    logic          r_txen;
    logic [7:0]    r_txdata;
    logic [2:0]    r_grant;
    logic [2:0]    r_rr_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_last_q;
    logic          r_err;

    logic [2:0]    w_gnt_idx;
    logic          w_gnt_vld;
    logic          w_sel_valid;
    logic [7:0]    w_sel_data;
    logic          w_sel_last;
    logic          w_hs;
    logic          w_done;
    logic          w_timeout;
    logic          w_release;
    logic [2:0]    w_next_ptr;
    logic [1:0]    w_nxt_state;

    uart_rr_arbiter #(.NCH(NCH)) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_vld)
    );

    // Owner's request lines, muxed by a compare loop so any NCH up to 8 indexes cleanly.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        req_ready   = '0;
        for (int j = 0; j < NCH; j++) begin
            if (r_grant == 3'(j)) begin
                w_sel_valid  = req_valid[j];
                w_sel_data   = req_data[8*j +: 8];
                w_sel_last   = req_last[j];
                req_ready[j] = (r_state == ST_SEND) && req_valid[j];
            end
        end
    end

    assign w_hs       = (r_state == ST_SEND) && w_sel_valid;
    // A TxDone seen while our own start pulse is out belongs to the previous frame.
    assign w_done     = (r_state == ST_WAIT_DONE) && TxDone && !r_txen;
    assign w_timeout  = ((r_state == ST_SEND) && !w_sel_valid && (r_cnt == HOLD_LAST)) ||
                        ((r_state == ST_WAIT_DONE) && !w_done && (r_cnt == TO_LAST));
    assign w_release  = w_timeout || (w_done && r_last_q);
    assign w_next_ptr = (r_grant == 3'(NCH - 1)) ? 3'd0 : r_grant + 3'd1;

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) w_nxt_state = ST_SEND;
            end
            ST_SEND: begin
                if (w_hs)           w_nxt_state = ST_WAIT_DONE;
                else if (w_timeout) w_nxt_state = ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (w_done)         w_nxt_state = r_last_q ? ST_IDLE : ST_SEND;
                else if (w_timeout) w_nxt_state = ST_IDLE;
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_txen  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_txen  <= w_hs;
            r_err   <= w_timeout;
            if (w_nxt_state != r_state)
                r_cnt <= '0;
            else if (r_state != ST_IDLE && r_cnt != CNT_SAT)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_txdata <= '0;
            r_last_q <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_gnt_vld)
                r_grant <= w_gnt_idx;
            if (w_hs) begin
                r_txdata <= w_sel_data;
                r_last_q <= w_sel_last;
            end
            if (w_release)
                r_rr_ptr <= w_next_ptr;
        end
    end

    assign TxEn     = r_txen;
    assign TxData   = r_txdata;
    assign grant_id = r_grant;
    assign busy     = (r_state != ST_IDLE);
    assign err_to   = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: requester queues feed the DUT, a transmitter model answers TxEn, and
// every TxEn is matched against the expected (owner, byte) sequence.
module tb_uart_tx_scheduler;

    localparam int NCH      = 4;
    localparam int TIMEOUT  = 64;
    localparam int HOLD_MAX = 32;

    logic             pClk = 1'b0;
    logic             pReset;
    logic [NCH-1:0]   req_valid;
    logic [8*NCH-1:0] req_data;
    logic [NCH-1:0]   req_last;
    logic [NCH-1:0]   req_ready;
    logic             TxDone;
    logic             TxEn;
    logic [7:0]       TxData;
    logic [2:0]       grant_id;
    logic             busy;
    logic             err_to;

    typedef struct {
        logic [2:0] ch;
        logic [7:0] d;
    } exp_t;

    exp_t       expq[$];
    logic [8:0] chq[NCH][$];
    int         txc[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    int         err_cnt = 0;
    int         txmode = 0;
    int         dcnt = -1;
    logic [NCH-1:0] hs_pend = '0;
    logic       prev_txen = 1'b0;

    uart_tx_scheduler #(.NCH(NCH), .TIMEOUT(TIMEOUT), .HOLD_MAX(HOLD_MAX)) dut (
        .pClk      (pClk),
        .pReset    (pReset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .TxDone    (TxDone),
        .TxEn      (TxEn),
        .TxData    (TxData),
        .grant_id  (grant_id),
        .busy      (busy),
        .err_to    (err_to)
    );

    always #5 pClk = ~pClk;
    always @(posedge pClk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int ch, input logic [7:0] d);
        exp_t e;
        e.ch = 3'(ch);
        e.d  = d;
        expq.push_back(e);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NCH; i++)
            if (chq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge pClk);
            #2;
            if (!busy && expq.size() == 0 && all_empty()) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_err(input string tag, input int budget, output int at);
        bit ok = 1'b0;
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge pClk);
            #2;
            if (err_to) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    // Requester queues and transmitter model; inputs change only at negedge.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        TxDone    = 1'b0;
        forever begin
            @(negedge pClk);
            for (int i = 0; i < NCH; i++)
                if (hs_pend[i] && chq[i].size() > 0) void'(chq[i].pop_front());
            for (int i = 0; i < NCH; i++) begin
                if (chq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = chq[i][0][7:0];
                    req_last[i]        = chq[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            if (!pReset) begin
                dcnt   = -1;
                TxDone = 1'b0;
            end else if (txmode == 2) begin
                TxDone = 1'b1;
            end else if (TxEn && txmode == 0) begin
                dcnt   = 10;
                TxDone = 1'b0;
            end else if (dcnt > 0) begin
                dcnt--;
                TxDone = (dcnt == 0);
            end else begin
                TxDone = 1'b0;
            end
            #1 hs_pend = req_valid & req_ready;
        end
    end

    // TxEn monitor: pops the scoreboard on every start pulse.
    initial begin
        forever begin
            @(negedge pClk);
            if (err_to) err_cnt++;
            if (TxEn) begin
                txc.push_back(cyc);
                chk("txen_pulse_width", 32'(prev_txen), 32'd0);
                if (expq.size() == 0) begin
                    chk("unexpected_txen", {21'd0, grant_id, TxData}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("txdata", 32'(TxData), 32'(e.d));
                    chk("grant_id", 32'(grant_id), 32'(e.ch));
                end
            end
            prev_txen = TxEn;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int e;
        pReset = 1'b0;
        repeat (3) @(posedge pClk);
        #1;
        chk("rst_txen", 32'(TxEn), 32'd0);
        chk("rst_txdata", 32'(TxData), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_to), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_ptr", 32'(dut.r_rr_ptr), 32'd0);
        pReset = 1'b1;
        repeat (2) @(posedge pClk);

        // 1: three-byte packet on ch1
        #2;
        t0 = cyc;
        chq[1].push_back({1'b0, 8'hA1});
        chq[1].push_back({1'b0, 8'hA2});
        chq[1].push_back({1'b1, 8'hA3});
        push_exp(1, 8'hA1); push_exp(1, 8'hA2); push_exp(1, 8'hA3);
        wait_idle("t1_idle", 200);
        chk("t1_first_latency", 32'(txc[$-2] - t0), 32'd2);
        chk("t1_gap12", 32'(txc[$-1] - txc[$-2]), 32'd12);
        chk("t1_gap23", 32'(txc[$] - txc[$-1]), 32'd12);
        chk("t1_ptr", 32'(dut.r_rr_ptr), 32'd2);

        // 2: move ptr to 0 via ch3, then concurrent ch0+ch2 twice
        @(posedge pClk); #2;
        chq[3].push_back({1'b1, 8'h33});
        push_exp(3, 8'h33);
        wait_idle("t2_prep", 100);
        chk("t2_ptr0", 32'(dut.r_rr_ptr), 32'd0);
        @(posedge pClk); #2;
        chq[0].push_back({1'b1, 8'h10});
        chq[2].push_back({1'b1, 8'h30});
        push_exp(0, 8'h10); push_exp(2, 8'h30);
        wait_idle("t2_pair1", 200);
        chk("t2_ptr3", 32'(dut.r_rr_ptr), 32'd3);
        @(posedge pClk); #2;
        chq[0].push_back({1'b1, 8'h11});
        chq[2].push_back({1'b1, 8'h31});
        push_exp(0, 8'h11); push_exp(2, 8'h31);
        wait_idle("t2_pair2", 200);

        // 3: ch3 owner stalls mid-packet while ch0 waits
        @(posedge pClk); #2;
        chq[3].push_back({1'b0, 8'h55});
        chq[0].push_back({1'b1, 8'h01});
        push_exp(3, 8'h55); push_exp(0, 8'h01);
        wait_err("t3_err_seen", 200, e);
        chk("t3_hold_time", 32'(e - txc[$]), 32'(11 + HOLD_MAX));
        wait_idle("t3_idle", 100);
        chk("t3_ch0_latency", 32'(txc[$] - e), 32'd2);
        chk("t3_ptr", 32'(dut.r_rr_ptr), 32'd1);

        // 4: transmitter never answers
        txmode = 1;
        @(posedge pClk); #2;
        chq[1].push_back({1'b1, 8'h7E});
        push_exp(1, 8'h7E);
        wait_err("t4_err_seen", TIMEOUT + 50, e);
        chk("t4_timeout", 32'(e - txc[$]), 32'(TIMEOUT));
        chk("t4_busy", 32'(busy), 32'd0);
        wait_idle("t4_idle", 20);

        // 5: TxDone stuck high
        txmode = 2;
        @(posedge pClk); #2;
        chq[2].push_back({1'b0, 8'h21});
        chq[2].push_back({1'b1, 8'h22});
        push_exp(2, 8'h21); push_exp(2, 8'h22);
        wait_idle("t5_idle", 100);
        chk("t5_gap", 32'(txc[$] - txc[$-1]), 32'd3);
        repeat (10) @(posedge pClk);
        txmode = 0;
        repeat (2) @(posedge pClk);

        // 6: reset while ch2 owns the transmitter
        #2;
        chq[2].push_back({1'b0, 8'hC1});
        chq[2].push_back({1'b1, 8'hC2});
        push_exp(2, 8'hC1);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 50; n++) begin
                @(negedge pClk); #2;
                if (TxEn) begin seen = 1'b1; break; end
            end
            chk("t6_txen_seen", 32'(seen), 32'd1);
        end
        #1 pReset = 1'b0;
        chq[2].delete();
        #1;
        chk("t6_txen", 32'(TxEn), 32'd0);
        chk("t6_txdata", 32'(TxData), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_grant", 32'(grant_id), 32'd0);
        chk("t6_ptr", 32'(dut.r_rr_ptr), 32'd0);
        repeat (2) @(posedge pClk);
        #2 pReset = 1'b1;
        @(posedge pClk); #2;
        chq[1].push_back({1'b1, 8'h99});
        push_exp(1, 8'h99);
        wait_idle("t6_after", 100);
        chk("t6_ptr_after", 32'(dut.r_rr_ptr), 32'd2);

        chk("total_err_pulses", 32'(err_cnt), 32'd2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
